// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default sizes, register address type and
// the index of the optional hard-wired zero register.
package cpu_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 4;
  localparam int ZERO_REG_IDX = 0;

  // Register address for the default register count.
  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;

endpackage : cpu_pkg

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, RAW/WAW stall detection
// and the clear-then-set update, where an issue's set beats a same-cycle clear.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [ADDR_W-1:0]   i_rs1,
  input  logic [ADDR_W-1:0]   i_rs2,
  input  logic [ADDR_W-1:0]   i_rd,
  input  logic                i_regdst,
  input  logic                i_issue_valid,
  input  logic                i_issue_writes,
  input  logic                i_wb_valid,
  input  logic [ADDR_W-1:0]   i_wb_addr,
  output logic                o_stall,
  output logic [NUM_REGS-1:0] o_busy
);

  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] KEEP_MASK =
      (ZERO_REG != 0) ? ~(ONE_HOT0 << ZERO_REG_IDX) : {NUM_REGS{1'b1}};

  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W-1:0]   w_dest;
  logic                w_haz_a;
  logic                w_haz_b;
  logic                w_haz_d;
  logic                w_stall;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Hazard detection: a busy source is fine if its value is being written back now.
  always_comb begin
    w_dest  = i_regdst ? i_rd : i_rs2;
    w_haz_a = r_busy[i_rs1]  && !(i_wb_valid && (i_wb_addr == i_rs1));
    w_haz_b = r_busy[i_rs2]  && !(i_wb_valid && (i_wb_addr == i_rs2));
    w_haz_d = r_busy[w_dest] && !(i_wb_valid && (i_wb_addr == w_dest));
    w_stall = i_issue_valid && (w_haz_a || w_haz_b || (i_issue_writes && w_haz_d));
  end

  // Next busy vector: clear on write-back, then set for an accepted writing issue.
  always_comb begin
    w_clr_mask = i_wb_valid ? (ONE_HOT0 << i_wb_addr) : {NUM_REGS{1'b0}};
    w_set_mask = (i_issue_valid && i_issue_writes && !w_stall) ?
                 (ONE_HOT0 << w_dest) : {NUM_REGS{1'b0}};
    w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & KEEP_MASK;
  end

  // Busy register with synchronous reset dropping every pending write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= {NUM_REGS{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_stall = w_stall;
  assign o_busy  = r_busy;

endmodule : reg_scoreboard

// File: rtl/regfile_scoreboard.sv
// Register file for the pipelined datapath: two bypassed combinational read
// ports, one write-back port, optional zero register and a hazard scoreboard.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   read_register1,
  input  logic [ADDR_W-1:0]   read_register2,
  input  logic [ADDR_W-1:0]   destination_register,
  input  logic                regdst,
  input  logic                issue_valid,
  input  logic                issue_writes,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [DATA_W-1:0]   readdata1,
  output logic [DATA_W-1:0]   readdata2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);
  localparam bit                HAS_ZERO  = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_en;

  assign w_wr_en = wb_valid && !(HAS_ZERO && (wb_addr == ZERO_ADDR));

  // Storage: synchronous reset clears all registers, otherwise accept write-back.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[wb_addr] <= wb_data;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Read port A: zero register first, then write-back bypass, then storage.
  always_comb begin
    if (HAS_ZERO && (read_register1 == ZERO_ADDR)) begin
      readdata1 = {DATA_W{1'b0}};
    end else if (wb_valid && (wb_addr == read_register1)) begin
      readdata1 = wb_data;
    end else begin
      readdata1 = r_regs[read_register1];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    if (HAS_ZERO && (read_register2 == ZERO_ADDR)) begin
      readdata2 = {DATA_W{1'b0}};
    end else if (wb_valid && (wb_addr == read_register2)) begin
      readdata2 = wb_data;
    end else begin
      readdata2 = r_regs[read_register2];
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk          (CLK),
    .i_reset        (RESET),
    .i_rs1          (read_register1),
    .i_rs2          (read_register2),
    .i_rd           (destination_register),
    .i_regdst       (regdst),
    .i_issue_valid  (issue_valid),
    .i_issue_writes (issue_writes),
    .i_wb_valid     (wb_valid),
    .i_wb_addr      (wb_addr),
    .o_stall        (stall),
    .o_busy         (busy)
  );

endmodule : regfile_scoreboard
